elastic_rr_arbiter: RTL

Round-robin arbiter that merges N elastic valid/ready request streams into one elastic output stream. Packets are locked: once a requester is granted, it owns the output until it sends a beat with last set. The merged output passes through one registered elastic stage, tagged with the source index. It sits in front of a shared elastic datapath stage, for example a shift stage shared between several producers.

---
 rtl/elastic_rr_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/elastic_rr_arbiter.sv
// elastic_rr_arbiter: round-robin merge of N valid/ready streams with packet locking
// and one registered output stage tagged with the source index.
module elastic_rr_arbiter #(
  parameter int N   = 4,
  parameter int DW  = 32,
  parameter int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*DW-1:0] t_data,
  input  logic [N-1:0]    t_valid,
  input  logic [N-1:0]    t_last,
  output logic [N-1:0]    t_ready,
  input  logic [N-1:0]    en,
  output logic [DW-1:0]   i_data,
  output logic [IDW-1:0]  i_id,
  output logic            i_last,
  output logic            i_valid,
  input  logic            i_ready,
  output logic            busy
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d, owner_q, owner_d;
  logic [DW-1:0]   data_q;
  logic [IDW-1:0]  id_q;
  logic            last_q, valid_q;
  logic [N-1:0]    elig;
  logic [IDW-1:0]  g, sel;
  logic            found, hit, acc, xfer;
  assign elig = t_valid & en;
  // Scan offsets downward so the smallest offset from ptr wins.
  always_comb begin
    found = 1'b0;
    g = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int j;
      j = (int'(ptr_q) + i) % N;
      if (elig[IDW'(j)]) begin
        found = 1'b1;
        g = IDW'(j);
      end
    end
  end
  assign acc     = ~rst & (~valid_q | i_ready);
  assign sel     = (state_q == LOCK) ? owner_q : g;
  assign hit     = (state_q == LOCK) | found;
  assign t_ready = (acc & hit) ? (N'(1) << sel) : '0;
  assign xfer    = |(t_valid & t_ready);
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (xfer) begin
      state_d = t_last[sel] ? IDLE : LOCK;
      ptr_d   = t_last[sel] ? ((sel == IDW'(N - 1)) ? '0 : sel + 1'b1) : ptr_q;
      owner_d = sel;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      data_q  <= '0;
      id_q    <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      if (xfer) begin
        data_q  <= t_data[int'(sel)*DW +: DW];
        id_q    <= sel;
        last_q  <= t_last[sel];
        valid_q <= 1'b1;
      end else if (i_ready) valid_q <= 1'b0;
    end
  end
  assign i_data  = data_q;
  assign i_id    = id_q;
  assign i_last  = last_q;
  assign i_valid = valid_q;
  assign busy    = (state_q == LOCK);
endmodule
